// File: rtl/nn_dma_pkg.sv
// Shared types and helpers for the nn DMA memory responder.
package nn_dma_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } rd_state_t;

    localparam int RD_LATENCY_MIN = 1;
    localparam int RD_LATENCY_MAX = 7;

    // True when any address bit above the memory index is set.
    function automatic logic addr_is_oob(input logic [31:0] addr, input int mem_addr_width);
        return (addr >> mem_addr_width) != 32'd0;
    endfunction

endpackage

// File: rtl/nn_dma_slave_if.sv
// Accelerator DMA and host access bundle seen by the memory responder.
interface nn_dma_slave_if #(
    parameter int DMA_ADDR_WIDTH = 16
);

    logic                      i_nn_rd_en;
    logic [DMA_ADDR_WIDTH-1:0] i_nn_rd_addr;
    logic [7:0]                o_nn_rd_data;
    logic                      o_nn_rd_ready;

    logic                      i_nn_wr_en;
    logic [DMA_ADDR_WIDTH-1:0] i_nn_wr_addr;
    logic [7:0]                i_nn_wr_data;

    logic                      i_host_req;
    logic                      i_host_we;
    logic [DMA_ADDR_WIDTH-1:0] i_host_addr;
    logic [7:0]                i_host_wdata;
    logic [7:0]                o_host_rdata;
    logic                      o_host_ack;

    modport master (
        output i_nn_rd_en, i_nn_rd_addr, i_nn_wr_en, i_nn_wr_addr, i_nn_wr_data,
        output i_host_req, i_host_we, i_host_addr, i_host_wdata,
        input  o_nn_rd_data, o_nn_rd_ready, o_host_rdata, o_host_ack
    );

    modport slave (
        input  i_nn_rd_en, i_nn_rd_addr, i_nn_wr_en, i_nn_wr_addr, i_nn_wr_data,
        input  i_host_req, i_host_we, i_host_addr, i_host_wdata,
        output o_nn_rd_data, o_nn_rd_ready, o_host_rdata, o_host_ack
    );

endinterface

// File: rtl/nn_dma_sram.sv
// Single-port synchronous byte memory; read data appears one cycle after the access.
module nn_dma_sram #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  i_clk,
    input  logic                  i_en,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [7:0]            i_wdata,
    output logic [7:0]            o_rdata
);

    logic [7:0] mem [0:(1<<ADDR_WIDTH)-1];

    // Writes leave the read register alone so earlier read data stays observable.
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (i_we) begin
                mem[i_addr] <= i_wdata;
            end else begin
                o_rdata <= mem[i_addr];
            end
        end
    end

endmodule

// File: rtl/nn_dma_slave.sv
// Memory-side responder for the accelerator DMA port plus a host load/drain port.
module nn_dma_slave
    import nn_dma_pkg::*;
#(
    parameter int DMA_ADDR_WIDTH = 16,
    parameter int MEM_ADDR_WIDTH = 12,
    parameter int RD_LATENCY     = 2,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    nn_dma_slave_if.slave        bus,
    input  logic                 i_clr,
    output logic [CNT_WIDTH-1:0] o_wr_count,
    output logic                 o_oob
);

    localparam logic [2:0] CNT_LOAD = 3'(RD_LATENCY - 1);

    if (RD_LATENCY < RD_LATENCY_MIN || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_rd_latency
        $error("nn_dma_slave: RD_LATENCY out of range");
    end

    rd_state_t state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    logic wr_oob, rd_oob, host_oob;
    logic nn_wr, rd_accept, host_grant, oob_event;

    logic       rd_cap_q, rd_cap_oob_q;
    logic [7:0] rd_data_q, rd_byte;
    logic       host_ack_q, host_rd_q, host_oob_q;

    logic                      sram_en, sram_we;
    logic [MEM_ADDR_WIDTH-1:0] sram_addr;
    logic [7:0]                sram_wdata, sram_rdata;

    assign wr_oob   = addr_is_oob(32'(bus.i_nn_wr_addr), MEM_ADDR_WIDTH);
    assign rd_oob   = addr_is_oob(32'(bus.i_nn_rd_addr), MEM_ADDR_WIDTH);
    assign host_oob = addr_is_oob(32'(bus.i_host_addr), MEM_ADDR_WIDTH);

    // One memory access per cycle: accelerator write, then read acceptance, then host.
    assign nn_wr      = bus.i_nn_wr_en;
    assign rd_accept  = (state_q == IDLE) && bus.i_nn_rd_en && !nn_wr;
    assign host_grant = bus.i_host_req && !nn_wr && !rd_accept && !host_ack_q;
    assign oob_event  = (nn_wr && wr_oob) || (rd_accept && rd_oob) || (host_grant && host_oob);

    always_comb begin
        sram_en    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = 8'h00;
        if (nn_wr) begin
            sram_en    = !wr_oob;
            sram_we    = 1'b1;
            sram_addr  = bus.i_nn_wr_addr[MEM_ADDR_WIDTH-1:0];
            sram_wdata = bus.i_nn_wr_data;
        end else if (rd_accept) begin
            sram_en    = !rd_oob;
            sram_addr  = bus.i_nn_rd_addr[MEM_ADDR_WIDTH-1:0];
        end else if (host_grant) begin
            sram_en    = !host_oob;
            sram_we    = bus.i_host_we;
            sram_addr  = bus.i_host_addr[MEM_ADDR_WIDTH-1:0];
            sram_wdata = bus.i_host_wdata;
        end
    end

    nn_dma_sram #(
        .ADDR_WIDTH (MEM_ADDR_WIDTH)
    ) u_sram (
        .i_clk   (i_clk),
        .i_en    (sram_en),
        .i_we    (sram_we),
        .i_addr  (sram_addr),
        .i_wdata (sram_wdata),
        .o_rdata (sram_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (rd_accept) begin
                    cnt_d   = CNT_LOAD;
                    state_d = (CNT_LOAD == 3'd0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The byte is taken from the memory in the cycle after acceptance, before anything can disturb it.
    assign rd_byte           = rd_cap_oob_q ? 8'h00 : sram_rdata;
    assign bus.o_nn_rd_ready = (state_q == RESP);
    assign bus.o_nn_rd_data  = (state_q == RESP) ? (rd_cap_q ? rd_byte : rd_data_q) : 8'h00;
    assign bus.o_host_ack    = host_ack_q;
    assign bus.o_host_rdata  = (host_ack_q && host_rd_q && !host_oob_q) ? sram_rdata : 8'h00;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q      <= IDLE;
            cnt_q        <= 3'd0;
            rd_cap_q     <= 1'b0;
            rd_cap_oob_q <= 1'b0;
            rd_data_q    <= 8'h00;
            host_ack_q   <= 1'b0;
            host_rd_q    <= 1'b0;
            host_oob_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rd_cap_q     <= rd_accept;
            rd_cap_oob_q <= rd_oob;
            if (rd_cap_q) begin
                rd_data_q <= rd_byte;
            end
            host_ack_q   <= host_grant;
            host_rd_q    <= !bus.i_host_we;
            host_oob_q   <= host_oob;
        end
    end

    // A clear loses to a same-cycle write or out-of-range event.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            o_wr_count <= '0;
            o_oob      <= 1'b0;
        end else if (i_clr) begin
            o_wr_count <= nn_wr ? CNT_WIDTH'(1) : '0;
            o_oob      <= oob_event;
        end else begin
            if (nn_wr && !(&o_wr_count)) begin
                o_wr_count <= o_wr_count + CNT_WIDTH'(1);
            end
            if (oob_event) begin
                o_oob <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nn_dma_slave.sv
// Directed self-checking bench for nn_dma_slave: host table plus multi-cycle corner sequences.
module tb_nn_dma_slave;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_rdata;
        logic        exp_oob;
    } host_vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic [15:0] wr_count;
    logic        oob;

    int checks = 0;
    int errors = 0;

    host_vec_t vecs [10];

    nn_dma_slave_if #(.DMA_ADDR_WIDTH(16)) bus ();

    nn_dma_slave #(
        .DMA_ADDR_WIDTH (16),
        .MEM_ADDR_WIDTH (12),
        .RD_LATENCY     (2),
        .CNT_WIDTH      (16)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .bus        (bus),
        .i_clr      (clr),
        .o_wr_count (wr_count),
        .o_oob      (oob)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Holds a host request until ack or a 20-cycle budget runs out.
    task automatic applyStimulus(input host_vec_t v, output logic [7:0] rdata, output logic got_ack);
        bus.i_host_req   = 1'b1;
        bus.i_host_we    = v.we;
        bus.i_host_addr  = v.addr;
        bus.i_host_wdata = v.wdata;
        got_ack = 1'b0;
        rdata   = 8'h00;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (bus.o_host_ack) begin
                got_ack = 1'b1;
                rdata   = bus.o_host_rdata;
                break;
            end
        end
        bus.i_host_req = 1'b0;
    endtask

    task automatic nnRead(input logic [15:0] addr, output logic [7:0] data, output int latency);
        bus.i_nn_rd_en   = 1'b1;
        bus.i_nn_rd_addr = addr;
        data    = 8'h00;
        latency = -1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (bus.o_nn_rd_ready) begin
                data    = bus.o_nn_rd_data;
                latency = n;
                break;
            end
        end
        bus.i_nn_rd_en = 1'b0;
    endtask

    initial begin
        logic [7:0] rd;
        logic       ok;
        logic       seen;
        int         lat;
        host_vec_t  hv;

        vecs[0] = '{1'b1, 16'h0010, 8'hA5, 8'h00, 1'b0};
        vecs[1] = '{1'b1, 16'h0011, 8'h3C, 8'h00, 1'b0};
        vecs[2] = '{1'b1, 16'h0FFF, 8'h7E, 8'h00, 1'b0};
        vecs[3] = '{1'b1, 16'h0000, 8'h99, 8'h00, 1'b0};
        vecs[4] = '{1'b0, 16'h0010, 8'h00, 8'hA5, 1'b0};
        vecs[5] = '{1'b0, 16'h0FFF, 8'h00, 8'h7E, 1'b0};
        vecs[6] = '{1'b1, 16'h1000, 8'h55, 8'h00, 1'b1};
        vecs[7] = '{1'b0, 16'h0000, 8'h00, 8'h99, 1'b1};
        vecs[8] = '{1'b0, 16'h8011, 8'h00, 8'h00, 1'b1};
        vecs[9] = '{1'b0, 16'h0011, 8'h00, 8'h3C, 1'b1};

        rst = 1'b0;
        clr = 1'b0;
        bus.i_nn_rd_en   = 1'b0;
        bus.i_nn_rd_addr = 16'h0000;
        bus.i_nn_wr_en   = 1'b0;
        bus.i_nn_wr_addr = 16'h0000;
        bus.i_nn_wr_data = 8'h00;
        bus.i_host_req   = 1'b0;
        bus.i_host_we    = 1'b0;
        bus.i_host_addr  = 16'h0000;
        bus.i_host_wdata = 8'h00;

        tick();
        tick();
        checkOutput("reset_rd_ready", 32'(bus.o_nn_rd_ready), 32'h0);
        checkOutput("reset_rd_data", 32'(bus.o_nn_rd_data), 32'h0);
        checkOutput("reset_host_ack", 32'(bus.o_host_ack), 32'h0);
        checkOutput("reset_host_rdata", 32'(bus.o_host_rdata), 32'h0);
        checkOutput("reset_wr_count", 32'(wr_count), 32'h0);
        checkOutput("reset_oob", 32'(oob), 32'h0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i], rd, ok);
            checkOutput($sformatf("host_ack[%0d]", i), 32'(ok), 32'h1);
            if (!vecs[i].we) begin
                checkOutput($sformatf("host_rdata[%0d]", i), 32'(rd), 32'(vecs[i].exp_rdata));
            end
            checkOutput($sformatf("host_oob[%0d]", i), 32'(oob), 32'(vecs[i].exp_oob));
            tick();
            checkOutput($sformatf("host_ack_single[%0d]", i), 32'(bus.o_host_ack), 32'h0);
        end

        // Accelerator read of host-loaded data: one pulse, two cycles after acceptance.
        nnRead(16'h0010, rd, lat);
        checkOutput("nn_read_latency", 32'(lat), 32'd2);
        checkOutput("nn_read_data", 32'(rd), 32'hA5);
        tick();
        checkOutput("nn_read_single_pulse", 32'(bus.o_nn_rd_ready), 32'h0);

        // Read deferred while the write strobe is held to the same address.
        bus.i_nn_rd_en   = 1'b1;
        bus.i_nn_rd_addr = 16'h0020;
        bus.i_nn_wr_en   = 1'b1;
        bus.i_nn_wr_addr = 16'h0020;
        for (int i = 0; i < 3; i++) begin
            bus.i_nn_wr_data = 8'h11 * 8'(i + 1);
            tick();
            checkOutput($sformatf("collide_no_ready[%0d]", i), 32'(bus.o_nn_rd_ready), 32'h0);
        end
        bus.i_nn_wr_en = 1'b0;
        lat = -1;
        rd  = 8'h00;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (bus.o_nn_rd_ready) begin
                lat = n;
                rd  = bus.o_nn_rd_data;
                break;
            end
        end
        bus.i_nn_rd_en = 1'b0;
        checkOutput("collide_latency", 32'(lat), 32'd2);
        checkOutput("collide_data", 32'(rd), 32'h33);
        checkOutput("collide_wr_count", 32'(wr_count), 32'd3);
        tick();

        // Host read starved by a 10-cycle write burst, granted right after it.
        bus.i_host_req  = 1'b1;
        bus.i_host_we   = 1'b0;
        bus.i_host_addr = 16'h0109;
        bus.i_nn_wr_en  = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.i_nn_wr_addr = 16'h0100 + 16'(i);
            bus.i_nn_wr_data = 8'h40 + 8'(i);
            tick();
            if (bus.o_host_ack) seen = 1'b1;
        end
        bus.i_nn_wr_en = 1'b0;
        checkOutput("burst_no_early_ack", 32'(seen), 32'h0);
        tick();
        checkOutput("burst_ack", 32'(bus.o_host_ack), 32'h1);
        checkOutput("burst_rdata", 32'(bus.o_host_rdata), 32'h49);
        bus.i_host_req = 1'b0;
        tick();
        checkOutput("burst_ack_single", 32'(bus.o_host_ack), 32'h0);
        checkOutput("burst_wr_count", 32'(wr_count), 32'd13);

        // Out-of-range accelerator read, then clear.
        nnRead(16'h1000, rd, lat);
        checkOutput("oob_read_latency", 32'(lat), 32'd2);
        checkOutput("oob_read_data", 32'(rd), 32'h00);
        checkOutput("oob_read_flag", 32'(oob), 32'h1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checkOutput("clr_oob", 32'(oob), 32'h0);
        checkOutput("clr_wr_count", 32'(wr_count), 32'h0);

        // Counter saturation.
        bus.i_nn_wr_en   = 1'b1;
        bus.i_nn_wr_addr = 16'h0200;
        bus.i_nn_wr_data = 8'h5A;
        repeat (65535) tick();
        checkOutput("sat_reach", 32'(wr_count), 32'hFFFF);
        repeat (2) tick();
        checkOutput("sat_hold", 32'(wr_count), 32'hFFFF);

        // Clear coinciding with an out-of-range write.
        clr = 1'b1;
        bus.i_nn_wr_addr = 16'h1234;
        tick();
        clr = 1'b0;
        bus.i_nn_wr_en = 1'b0;
        checkOutput("clr_with_write_count", 32'(wr_count), 32'h1);
        checkOutput("clr_with_write_oob", 32'(oob), 32'h1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checkOutput("clr_again_count", 32'(wr_count), 32'h0);
        checkOutput("clr_again_oob", 32'(oob), 32'h0);

        // Reset while a read is waiting.
        bus.i_nn_wr_en   = 1'b1;
        bus.i_nn_wr_addr = 16'h0300;
        bus.i_nn_wr_data = 8'hC3;
        tick();
        bus.i_nn_wr_en   = 1'b0;
        bus.i_nn_rd_en   = 1'b1;
        bus.i_nn_rd_addr = 16'h0300;
        tick();
        rst = 1'b0;
        bus.i_nn_rd_en = 1'b0;
        seen = 1'b0;
        tick();
        if (bus.o_nn_rd_ready) seen = 1'b1;
        checkOutput("rst_mid_rd_data", 32'(bus.o_nn_rd_data), 32'h0);
        checkOutput("rst_mid_wr_count", 32'(wr_count), 32'h0);
        tick();
        if (bus.o_nn_rd_ready) seen = 1'b1;
        rst = 1'b1;
        repeat (3) begin
            tick();
            if (bus.o_nn_rd_ready) seen = 1'b1;
        end
        checkOutput("rst_mid_no_ready", 32'(seen), 32'h0);
        nnRead(16'h0300, rd, lat);
        checkOutput("post_rst_latency", 32'(lat), 32'd2);
        checkOutput("post_rst_data", 32'(rd), 32'hC3);
        tick();
        hv = '{1'b0, 16'h0011, 8'h00, 8'h3C, 1'b0};
        applyStimulus(hv, rd, ok);
        checkOutput("post_rst_host_ack", 32'(ok), 32'h1);
        checkOutput("post_rst_host_rdata", 32'(rd), 32'(hv.exp_rdata));
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
